fpu_round_pack: RTL
===================

Name: fpu_round_pack

Overview:
- Parametrised two-stage pipelined normalise/round/pack unit shared by the FPU datapaths (add, mult, div, sqrt, int convert).
- Takes an unpacked result: sign, special flags, wide signed exponent, mantissa with overflow/hidden bits, and 3 guard bits.
- Normalises, rounds per the 4-mode round field, packs to IEEE layout of configurable width, and raises exception flags.
- Valid/ready on both sides so it sits directly behind any producer stage. Replaces per-unit fixed float-only rounding.

Parameters:
EXP_WIDTH, 8, exponent field width (8 float, 11 double)
MANT_WIDTH, 23, stored mantissa field width (23 float, 52 double)
NAN_VALUE, all ones (1+EXP_WIDTH+MANT_WIDTH bits), canonical NaN output pattern

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  unit can accept beat
in_sign  in  1  result sign
in_nan  in  1  result is NaN
in_inf  in  1  result is infinity
in_zero  in  1  result is zero
in_exponent  in  EXP_WIDTH+2  signed biased exponent of in_mantissa bit MANT_WIDTH
in_mantissa  in  MANT_WIDTH+2  bit MANT_WIDTH+1 overflow, bit MANT_WIDTH hidden, rest fraction
in_guard  in  3  {g1, g0, sticky} below mantissa LSB
in_mode  in  2  0 EVEN, 1 DOWN, 2 UP, 3 ZERO
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts beat
out_result  out  1+EXP_WIDTH+MANT_WIDTH  packed {sign, exponent, mantissa}
out_inexact  out  1  rounding discarded nonzero bits
out_overflow  out  1  exponent exceeded max finite
out_underflow  out  1  result flushed to zero

Behaviour:
- Reset: both stage valids 0, out_valid 0, out_result 0, all flags 0. Reset mid-stream discards in-flight beats; no beat emitted until a new input is accepted.
- Handshake: beat transfers on valid&&ready each side. Stage n loads when empty or its content advances the same cycle. in_ready = !s1_valid || (s1 advancing). out_valid/out_result/flags stable while out_valid && !out_ready. Full throughput. Latency 2 cycles (accept at cycle N, out_valid at N+2) without backpressure. Max 2 beats held; order preserved.
- Special priority: nan > inf > zero > normal. NaN -> NAN_VALUE, flags 0. Inf -> {sign, all-ones, 0}, flags 0. Zero -> {sign, 0, 0}, flags 0. Specials bypass rounding but keep the same 2-cycle latency.
- Stage 1, normalise:
  - If mantissa bit MANT_WIDTH+1 set: shift right 1, exponent+1, new guard = {old LSB, old g1, old g0|sticky}.
  - Else: shift {mantissa, g1, g0} left by leading-zero count until the hidden bit is 1; exponent -= count; sticky unchanged.
  - All-zero mantissa with no guard bits: treat as zero.
  - Nonzero mantissa or guard bits are always fully normalised.
- Stage 2, round:
  - Definitions: r = g1, s = g0|sticky, lsb = mantissa bit 0.
  - Increment rule: EVEN r&(s|lsb); UP (r|s)&!sign; DOWN (r|s)&sign; ZERO never.
  - inexact = r|s.
  - Carry out of hidden bit: mantissa becomes hidden-only, exponent+1.
- Range (on post-round exponent, signed compare):
  - exponent <= 0: flush to {sign,0,0}, underflow=1, inexact=1. No denormal output.
  - exponent >= 2^EXP_WIDTH-1: overflow=1, inexact=1. Result is inf for EVEN, UP with sign 0, DOWN with sign 1. Otherwise max finite {sign, all-ones-minus-1, all-ones}.
  - Otherwise pack {sign, exponent[EXP_WIDTH-1:0], mantissa[MANT_WIDTH-1:0]}.
- Mode values are taken per beat. Out-of-range encodings cannot occur (2-bit field).

Test Plan:
1. Float defaults; exp=127, mant=0x0800000, guard=000, EVEN -> 0x3F800000 at +2 cycles, all flags 0.
2. Ties, EVEN: mant=0x0800001, guard=100 -> 0x3F800002 inexact=1. Mant=0x0800000, guard=100 -> 0x3F800000 inexact=1.
3. Round carry: exp=127, mant=0x0FFFFFF, guard=100, EVEN -> 0x40000000. Same beat in ZERO -> 0x3FFFFFFF.
4. Overflow, exp=254, mant=0x0FFFFFF, guard=100:
   - EVEN -> 0x7F800000, overflow=1, inexact=1.
   - ZERO -> 0x7F7FFFFF.
   - Normalise-left input exp=10, mant=0x0000001 -> exponent=-13, 0x00000000, underflow=1.
5. Backpressure: 4 back-to-back beats, out_ready=0 for 3 cycles -> in_ready low after 2 held beats; all 4 emerge in order, unchanged; out_result stable while stalled.
6. Specials plus reset, EXP_WIDTH=11/MANT_WIDTH=52 instance:
   - in_nan -> all ones.
   - in_inf with sign 1 -> 0xFFF0000000000000.
   - rst asserted with 2 beats in flight -> out_valid 0 next cycle, no beats emitted afterwards.

Source files
------------

// File: rtl/fpu_round_pack.sv
// Normalise, round and pack an unpacked FP result into IEEE layout and raise inexact/overflow/underflow.
// Latency 2 cycles (stage 1 normalise, stage 2 round + range + pack); one beat per cycle sustained.
// out_ready low freezes stage 2, stage 1 fills behind it, then in_ready drops; at most 2 beats held.
module fpu_round_pack #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter logic [EXP_WIDTH+MANT_WIDTH:0] NAN_VALUE = '1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_sign,
    input  logic                            in_nan,
    input  logic                            in_inf,
    input  logic                            in_zero,
    input  logic [EXP_WIDTH+1:0]            in_exponent,
    input  logic [MANT_WIDTH+1:0]           in_mantissa,
    input  logic [2:0]                      in_guard,
    input  logic [1:0]                      in_mode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [EXP_WIDTH+MANT_WIDTH:0]   out_result,
    output logic                            out_inexact,
    output logic                            out_overflow,
    output logic                            out_underflow
);
    localparam int RW  = 1 + EXP_WIDTH + MANT_WIDTH;
    // Internal exponent is wide enough that a full left normalise of the most
    // negative input exponent cannot wrap.
    localparam int EI  = EXP_WIDTH + 10;
    // Normalise window: {hidden, fraction, g1, g0}.
    localparam int NW  = MANT_WIDTH + 3;
    localparam int LZW = $clog2(NW + 1);
    localparam logic [EI-1:0] EXP_MAX = EI'((1 << EXP_WIDTH) - 1);

    localparam logic [1:0] MODE_EVEN = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_UP   = 2'd2;
    localparam logic [1:0] MODE_ZERO = 2'd3;

    typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_t;

    // ---------------- handshake ----------------
    logic s1_vld_q, s1_vld_d;
    logic s2_vld_q, s2_vld_d;
    logic s1_load, s2_load;

    assign s2_load  = !s2_vld_q || out_ready;
    assign s1_load  = !s1_vld_q || s2_load;
    assign in_ready = s1_load;

    // ---------------- stage 1: normalise ----------------
    logic                  s1_sign_q, s1_sign_d;
    kind_t                 s1_kind_q, s1_kind_d;
    logic [EI-1:0]         s1_exp_q,  s1_exp_d;
    logic [MANT_WIDTH:0]   s1_mant_q, s1_mant_d;
    logic                  s1_rnd_q,  s1_rnd_d;
    logic                  s1_stk_q,  s1_stk_d;
    logic [1:0]            s1_mode_q, s1_mode_d;

    logic [EI-1:0]         exp_ext;
    logic [NW-1:0]         win;
    logic [NW-1:0]         win_sh;
    logic [LZW-1:0]        lzc;

    // Classify the incoming beat and bring its mantissa to 1.xxx form with round/sticky bits.
    always_comb begin
        exp_ext = {{(EI-EXP_WIDTH-2){in_exponent[EXP_WIDTH+1]}}, in_exponent};
        win     = {in_mantissa[MANT_WIDTH:0], in_guard[2:1]};
        lzc     = LZW'(NW);
        for (int i = 0; i < NW; i++) begin
            if (win[i]) lzc = LZW'(NW - 1 - i);
        end
        win_sh  = win << lzc;

        s1_vld_d  = s1_vld_q;
        s1_sign_d = s1_sign_q;
        s1_kind_d = s1_kind_q;
        s1_exp_d  = s1_exp_q;
        s1_mant_d = s1_mant_q;
        s1_rnd_d  = s1_rnd_q;
        s1_stk_d  = s1_stk_q;
        s1_mode_d = s1_mode_q;

        if (s1_load) begin
            s1_vld_d  = in_valid;
            s1_sign_d = in_sign;
            s1_mode_d = in_mode;
            s1_kind_d = K_NORM;
            s1_exp_d  = exp_ext;
            s1_mant_d = in_mantissa[MANT_WIDTH:0];
            s1_rnd_d  = 1'b0;
            s1_stk_d  = 1'b0;
            if (in_nan) begin
                s1_kind_d = K_NAN;
            end else if (in_inf) begin
                s1_kind_d = K_INF;
            end else if (in_zero) begin
                s1_kind_d = K_ZERO;
            end else if (in_mantissa[MANT_WIDTH+1]) begin
                // Mantissa overflowed into 2.xxx: one right shift, LSB becomes the round bit.
                s1_mant_d = in_mantissa[MANT_WIDTH+1:1];
                s1_exp_d  = exp_ext + EI'(1);
                s1_rnd_d  = in_mantissa[0];
                s1_stk_d  = |in_guard;
            end else if (win == '0) begin
                if (in_guard[0]) begin
                    // Only the sticky bit survives: nonzero but far below any
                    // normal, so force it into the underflow range.
                    s1_mant_d = '0;
                    s1_exp_d  = '0;
                    s1_stk_d  = 1'b1;
                end else begin
                    s1_kind_d = K_ZERO;
                end
            end else begin
                s1_mant_d = win_sh[NW-1:2];
                s1_rnd_d  = win_sh[1];
                s1_stk_d  = win_sh[0] | in_guard[0];
                s1_exp_d  = exp_ext - {{(EI-LZW){1'b0}}, lzc};
            end
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_kind_q <= K_NORM;
            s1_exp_q  <= '0;
            s1_mant_q <= '0;
            s1_rnd_q  <= 1'b0;
            s1_stk_q  <= 1'b0;
            s1_mode_q <= MODE_EVEN;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_sign_q <= s1_sign_d;
            s1_kind_q <= s1_kind_d;
            s1_exp_q  <= s1_exp_d;
            s1_mant_q <= s1_mant_d;
            s1_rnd_q  <= s1_rnd_d;
            s1_stk_q  <= s1_stk_d;
            s1_mode_q <= s1_mode_d;
        end
    end

    // ---------------- stage 2: round, range check, pack ----------------
    logic [RW-1:0]         s2_res_q, s2_res_d;
    logic                  s2_inx_q, s2_inx_d;
    logic                  s2_ovf_q, s2_ovf_d;
    logic                  s2_unf_q, s2_unf_d;

    logic                  inc;
    logic                  sticky_any;
    logic                  to_inf;
    logic [MANT_WIDTH+1:0] sum;
    logic [MANT_WIDTH:0]   rmant;
    logic [EI-1:0]         rexp;

    // Apply the rounding increment, fold the carry into the exponent and map onto the output range.
    always_comb begin
        sticky_any = s1_rnd_q | s1_stk_q;
        inc = 1'b0;
        case (s1_mode_q)
            MODE_EVEN: inc = s1_rnd_q & (s1_stk_q | s1_mant_q[0]);
            MODE_DOWN: inc = sticky_any & s1_sign_q;
            MODE_UP:   inc = sticky_any & !s1_sign_q;
            MODE_ZERO: inc = 1'b0;
            default:   inc = 1'b0;
        endcase

        sum = {1'b0, s1_mant_q} + {{(MANT_WIDTH+1){1'b0}}, inc};
        if (sum[MANT_WIDTH+1]) begin
            rmant = {1'b1, {MANT_WIDTH{1'b0}}};
            rexp  = s1_exp_q + EI'(1);
        end else begin
            rmant = sum[MANT_WIDTH:0];
            rexp  = s1_exp_q;
        end

        // Overflow goes to infinity only when the mode rounds away from zero for this sign.
        to_inf = (s1_mode_q == MODE_EVEN) ||
                 (s1_mode_q == MODE_UP   && !s1_sign_q) ||
                 (s1_mode_q == MODE_DOWN &&  s1_sign_q);

        s2_vld_d = s2_vld_q;
        s2_res_d = s2_res_q;
        s2_inx_d = s2_inx_q;
        s2_ovf_d = s2_ovf_q;
        s2_unf_d = s2_unf_q;

        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            s2_inx_d = 1'b0;
            s2_ovf_d = 1'b0;
            s2_unf_d = 1'b0;
            case (s1_kind_q)
                K_NAN:  s2_res_d = NAN_VALUE;
                K_INF:  s2_res_d = {s1_sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                K_ZERO: s2_res_d = {s1_sign_q, {(RW-1){1'b0}}};
                default: begin
                    s2_inx_d = sticky_any;
                    if (rexp[EI-1] || rexp == '0) begin
                        s2_res_d = {s1_sign_q, {(RW-1){1'b0}}};
                        s2_unf_d = 1'b1;
                        s2_inx_d = 1'b1;
                    end else if (rexp >= EXP_MAX) begin
                        s2_ovf_d = 1'b1;
                        s2_inx_d = 1'b1;
                        if (to_inf) begin
                            s2_res_d = {s1_sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                        end else begin
                            s2_res_d = {s1_sign_q, {(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};
                        end
                    end else begin
                        s2_res_d = {s1_sign_q, rexp[EXP_WIDTH-1:0], rmant[MANT_WIDTH-1:0]};
                    end
                end
            endcase
        end
    end

    // Stage 2 register; doubles as the output holding register during backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            s2_res_q <= '0;
            s2_inx_q <= 1'b0;
            s2_ovf_q <= 1'b0;
            s2_unf_q <= 1'b0;
        end else begin
            s2_vld_q <= s2_vld_d;
            s2_res_q <= s2_res_d;
            s2_inx_q <= s2_inx_d;
            s2_ovf_q <= s2_ovf_d;
            s2_unf_q <= s2_unf_d;
        end
    end

    assign out_valid     = s2_vld_q;
    assign out_result    = s2_res_q;
    assign out_inexact   = s2_inx_q;
    assign out_overflow  = s2_ovf_q;
    assign out_underflow = s2_unf_q;

endmodule
